// File: rtl/wb_arbiter.sv
// Write-back arbiter: two one-entry holding buffers drained oldest-first into the
// single regfile write port, with read-hazard detection for accepted but unwritten results.
module wb_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              stall
);

  logic              va_q, va_d;
  logic              vb_q, vb_d;
  logic [ADDR_W-1:0] adr_a_q, adr_a_d;
  logic [ADDR_W-1:0] adr_b_q, adr_b_d;
  logic [DATA_W-1:0] dat_a_q, dat_a_d;
  logic [DATA_W-1:0] dat_b_q, dat_b_d;
  logic              a_older_q, a_older_d;

  logic grant_a, grant_b;
  logic a_load, b_load;
  logic hz1, hz2;

  // Grant depends only on buffer state, so valid never reaches we combinationally.
  assign grant_a = va_q & (~vb_q | a_older_q);
  assign grant_b = vb_q & ~grant_a;

  assign a_ready = ~rst & (~va_q | grant_a);
  assign b_ready = ~rst & (~vb_q | grant_b);

  // Writes to x0 complete the handshake but are never buffered.
  assign a_load = a_valid & a_ready & (a_addr != '0);
  assign b_load = b_valid & b_ready & (b_addr != '0);

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (grant_a) begin
      we    = 1'b1;
      waddr = adr_a_q;
      wdata = dat_a_q;
    end else if (grant_b) begin
      we    = 1'b1;
      waddr = adr_b_q;
      wdata = dat_b_q;
    end
  end

  // The granted buffer is covered by the regfile bypass; only the other one stalls.
  assign hz1 = re1 & (raddr1 != '0) &
               ((va_q & ~grant_a & (adr_a_q == raddr1)) |
                (vb_q & ~grant_b & (adr_b_q == raddr1)));
  assign hz2 = re2 & (raddr2 != '0) &
               ((va_q & ~grant_a & (adr_a_q == raddr2)) |
                (vb_q & ~grant_b & (adr_b_q == raddr2)));
  assign stall = hz1 | hz2;

  always_comb begin
    va_d      = va_q;
    vb_d      = vb_q;
    adr_a_d   = adr_a_q;
    adr_b_d   = adr_b_q;
    dat_a_d   = dat_a_q;
    dat_b_d   = dat_b_q;
    a_older_d = a_older_q;

    if (a_load) begin
      va_d    = 1'b1;
      adr_a_d = a_addr;
      dat_a_d = a_data;
    end else if (grant_a) begin
      va_d = 1'b0;
    end

    if (b_load) begin
      vb_d    = 1'b1;
      adr_b_d = b_addr;
      dat_b_d = b_data;
    end else if (grant_b) begin
      vb_d = 1'b0;
    end

    // Age tracks acceptance order so same-destination writes retire in order.
    if (a_load && b_load) begin
      a_older_d = 1'b1;
    end else if (a_load && vb_q && !grant_b) begin
      a_older_d = 1'b0;
    end else if (b_load && va_q && !grant_a) begin
      a_older_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      va_q      <= 1'b0;
      vb_q      <= 1'b0;
      adr_a_q   <= '0;
      adr_b_q   <= '0;
      dat_a_q   <= '0;
      dat_b_q   <= '0;
      a_older_q <= 1'b1;
    end else begin
      va_q      <= va_d;
      vb_q      <= vb_d;
      adr_a_q   <= adr_a_d;
      adr_b_q   <= adr_b_d;
      dat_a_q   <= dat_a_d;
      dat_b_q   <= dat_b_d;
      a_older_q <= a_older_d;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid, a_ready, b_valid, b_ready;
  logic [4:0]  a_addr, b_addr, waddr, raddr1, raddr2;
  logic [31:0] a_data, b_data, wdata;
  logic        we, re1, re2, stall;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re1     (re1),
    .re2     (re2),
    .raddr1  (raddr1),
    .raddr2  (raddr2),
    .stall   (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_write(input string tag, input logic exp_we,
                           input logic [4:0] exp_addr, input logic [31:0] exp_data);
    chk({tag, ".we"}, {31'b0, we}, {31'b0, exp_we});
    chk({tag, ".waddr"}, {27'b0, waddr}, {27'b0, exp_addr});
    chk({tag, ".wdata"}, wdata, exp_data);
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
    re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;

    // Reset held two cycles with both valids high
    #1;
    chk("rst.a_ready", {31'b0, a_ready}, 32'd0);
    chk("rst.b_ready", {31'b0, b_ready}, 32'd0);
    step();
    chk_write("rst1", 1'b0, 5'd0, 32'd0);
    chk("rst1.a_ready", {31'b0, a_ready}, 32'd0);
    chk("rst1.b_ready", {31'b0, b_ready}, 32'd0);
    step();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk_write("post_rst", 1'b0, 5'd0, 32'd0);
    chk("post_rst.a_ready", {31'b0, a_ready}, 32'd1);
    chk("post_rst.b_ready", {31'b0, b_ready}, 32'd1);
    chk("post_rst.stall", {31'b0, stall}, 32'd0);
    step();
    chk_write("post_rst2", 1'b0, 5'd0, 32'd0);

    // Single A transfer
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
    #1;
    chk("single.a_ready", {31'b0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    #1;
    chk_write("single.k1", 1'b1, 5'd5, 32'h1234);
    step();
    chk_write("single.k2", 1'b0, 5'd0, 32'd0);

    // Same destination from both sources on one edge: A first, then B
    a_valid = 1'b1; a_addr = 5'd7; a_data = 32'hA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hB;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    chk_write("waw.1", 1'b1, 5'd7, 32'hA);
    chk("waw.1.b_ready", {31'b0, b_ready}, 32'd0);
    chk("waw.1.a_ready", {31'b0, a_ready}, 32'd1);
    step();
    chk_write("waw.2", 1'b1, 5'd7, 32'hB);
    chk("waw.2.b_ready", {31'b0, b_ready}, 32'd1);
    step();
    chk_write("waw.3", 1'b0, 5'd0, 32'd0);

    // Hazard: A(3) granted first, B(4) waiting
    a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h55;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h66;
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    re1 = 1'b1; raddr1 = 5'd4;
    #1;
    chk("hz.waiting", {31'b0, stall}, 32'd1);
    chk_write("hz.wr1", 1'b1, 5'd3, 32'h55);
    raddr1 = 5'd3;
    #1;
    chk("hz.granted", {31'b0, stall}, 32'd0);
    re1 = 1'b0; re2 = 1'b1; raddr2 = 5'd4;
    #1;
    chk("hz.port2", {31'b0, stall}, 32'd1);
    re2 = 1'b0; raddr2 = 5'd0;
    step();
    re1 = 1'b1; raddr1 = 5'd4;
    #1;
    chk("hz.now_granted", {31'b0, stall}, 32'd0);
    chk_write("hz.wr2", 1'b1, 5'd4, 32'h66);
    re1 = 1'b0;
    step();

    // x0 drop
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFF;
    #1;
    chk("x0.b_ready", {31'b0, b_ready}, 32'd1);
    step();
    b_valid = 1'b0;
    re1 = 1'b1; raddr1 = 5'd0;
    #1;
    chk_write("x0.k1", 1'b0, 5'd0, 32'd0);
    chk("x0.stall", {31'b0, stall}, 32'd0);
    re1 = 1'b0;
    step();
    chk_write("x0.k2", 1'b0, 5'd0, 32'd0);

    // Age: A refilled while B waits makes B the older entry
    a_valid = 1'b1; a_addr = 5'd10; a_data = 32'h1;
    b_valid = 1'b1; b_addr = 5'd11; b_data = 32'h2;
    step();
    b_valid = 1'b0; a_addr = 5'd12; a_data = 32'h3;
    #1;
    chk_write("age.1", 1'b1, 5'd10, 32'h1);
    chk("age.1.a_ready", {31'b0, a_ready}, 32'd1);
    step();
    a_valid = 1'b0;
    #1;
    chk_write("age.2", 1'b1, 5'd11, 32'h2);
    step();
    chk_write("age.3", 1'b1, 5'd12, 32'h3);
    step();
    chk_write("age.4", 1'b0, 5'd0, 32'd0);

    // Reset mid-operation drops both pending results
    a_valid = 1'b1; a_addr = 5'd13; a_data = 32'hD;
    b_valid = 1'b1; b_addr = 5'd14; b_data = 32'hE;
    step();
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b1;
    #1;
    chk("mrst.a_ready", {31'b0, a_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk_write("mrst.1", 1'b0, 5'd0, 32'd0);
    chk("mrst.b_ready", {31'b0, b_ready}, 32'd1);
    step();
    chk_write("mrst.2", 1'b0, 5'd0, 32'd0);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h1;
    step();
    a_valid = 1'b0;
    #1;
    chk_write("mrst.new", 1'b1, 5'd9, 32'h1);
    step();
    chk_write("mrst.idle", 1'b0, 5'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
